// File: rtl/sa_tile_scheduler_if.sv
// Handshake bundle for sa_tile_scheduler: job control, systolic-array wrapper handshake,
// tile indices and the downstream tile handshake. Signal directions are named from the scheduler's side.
interface sa_tile_scheduler_if #(
  parameter int TILE_R = 4,
  parameter int TILE_C = 4
);
  localparam int RW = (TILE_R > 1) ? $clog2(TILE_R) : 1;
  localparam int CW = (TILE_C > 1) ? $clog2(TILE_C) : 1;

  logic          i_start;
  logic          i_abort;
  logic          i_sa_out_vld;
  logic          i_tile_rdy;
  logic          o_sa_start;
  logic          o_sa_sync_rstn;
  logic [RW-1:0] o_row_idx;
  logic [CW-1:0] o_col_idx;
  logic          o_tile_vld;
  logic          o_busy;
  logic          o_done;
  logic          o_err;

  modport slave (
    input  i_start, i_abort, i_sa_out_vld, i_tile_rdy,
    output o_sa_start, o_sa_sync_rstn, o_row_idx, o_col_idx,
           o_tile_vld, o_busy, o_done, o_err
  );

  modport master (
    output i_start, i_abort, i_sa_out_vld, i_tile_rdy,
    input  o_sa_start, o_sa_sync_rstn, o_row_idx, o_col_idx,
           o_tile_vld, o_busy, o_done, o_err
  );
endinterface

// File: rtl/sa_tile_scheduler.sv
// Walks a TILE_R x TILE_C output-tile grid through one systolic array: clear, start, wait, hand off.
// Optional RUN-state watchdog enabled by defining SA_SCHED_TIMEOUT_EN.
module sa_tile_scheduler #(
  parameter int TILE_R      = 4,
  parameter int TILE_C      = 4,
  parameter int TIMEOUT_CYC = 1023
) (
  input  logic                i_clk,
  input  logic                i_asyn_rstn,
  sa_tile_scheduler_if.slave  bus
);
  localparam int RW = (TILE_R > 1) ? $clog2(TILE_R) : 1;
  localparam int CW = (TILE_C > 1) ? $clog2(TILE_C) : 1;
  localparam logic [RW-1:0] ROW_LAST = RW'(TILE_R - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(TILE_C - 1);

  if (TILE_R < 1 || TILE_C < 1 || TIMEOUT_CYC < 1) begin : g_bad_cfg
    $error("sa_tile_scheduler: TILE_R, TILE_C and TIMEOUT_CYC must all be >= 1");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_LOAD,
    S_RUN,
    S_ACK,
    S_DONE
  } state_e;

  state_e        r_state;
  state_e        w_next;
  logic [RW-1:0] r_row;
  logic [CW-1:0] r_col;
  logic          w_start_ok;
  logic          w_accept;
  logic          w_last;
  logic          w_timeout;
  logic          w_err;

  logic          w_sa_start;
  logic          w_sa_sync_rstn;
  logic          w_tile_vld;
  logic          w_busy;
  logic          w_done;

  assign w_start_ok = (r_state == S_IDLE) && bus.i_start;
  assign w_last     = (r_row == ROW_LAST) && (r_col == COL_LAST);
  assign w_accept   = (r_state == S_ACK) && bus.i_tile_rdy && !bus.i_abort;

`ifdef SA_SCHED_TIMEOUT_EN
  localparam int WDW = $clog2(TIMEOUT_CYC + 1);

  logic [WDW-1:0] r_wd;
  logic           r_err;

  // Held at zero outside RUN, so every RUN entry starts counting from zero.
  always_ff @(posedge i_clk or negedge i_asyn_rstn) begin
    if (!i_asyn_rstn)          r_wd <= '0;
    else if (r_state != S_RUN) r_wd <= '0;
    else                       r_wd <= r_wd + 1'b1;
  end

  assign w_timeout = (r_state == S_RUN) && !bus.i_sa_out_vld &&
                     (r_wd == WDW'(TIMEOUT_CYC - 1));

  always_ff @(posedge i_clk or negedge i_asyn_rstn) begin
    if (!i_asyn_rstn)                  r_err <= 1'b0;
    else if (w_start_ok)               r_err <= 1'b0;
    else if (w_timeout && !bus.i_abort) r_err <= 1'b1;
  end

  assign w_err = r_err;
`else
  assign w_timeout = 1'b0;
  assign w_err     = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_asyn_rstn) begin
    if (!i_asyn_rstn) r_state <= S_IDLE;
    else              r_state <= w_next;
  end

  always_comb begin
    // NOTE: default assignment first, so no path leaves w_next unassigned and no latch is inferred.
    w_next = r_state;
    if (r_state != S_IDLE && bus.i_abort) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: if (bus.i_start) w_next = S_CLR;
        S_CLR:  w_next = S_LOAD;
        S_LOAD: w_next = S_RUN;
        S_RUN: begin
          if (bus.i_sa_out_vld) w_next = S_ACK;
          else if (w_timeout)   w_next = S_IDLE;
        end
        S_ACK:  if (bus.i_tile_rdy) w_next = w_last ? S_DONE : S_CLR;
        S_DONE: w_next = S_IDLE;
        default: w_next = S_IDLE;
      endcase
    end
  end

  // Column index is the inner loop; row advances when the column wraps.
  always_ff @(posedge i_clk or negedge i_asyn_rstn) begin
    if (!i_asyn_rstn) begin
      r_row <= '0;
      r_col <= '0;
    end else if (w_start_ok) begin
      r_row <= '0;
      r_col <= '0;
    end else if (w_accept && !w_last) begin
      if (r_col == COL_LAST) begin
        r_col <= '0;
        r_row <= r_row + 1'b1;
      end else begin
        r_col <= r_col + 1'b1;
      end
    end
  end

  always_comb begin
    w_sa_start     = 1'b0;
    w_sa_sync_rstn = 1'b1;
    w_tile_vld     = 1'b0;
    w_busy         = 1'b0;
    w_done         = 1'b0;
    case (r_state)
      S_IDLE: w_sa_sync_rstn = 1'b0;
      S_CLR: begin
        w_sa_sync_rstn = 1'b0;
        w_busy         = 1'b1;
      end
      S_LOAD: begin
        w_sa_start = 1'b1;
        w_busy     = 1'b1;
      end
      S_RUN:  w_busy = 1'b1;
      S_ACK: begin
        w_tile_vld = 1'b1;
        w_busy     = 1'b1;
      end
      S_DONE: w_done = 1'b1;
      default: w_sa_sync_rstn = 1'b0;
    endcase
  end

  assign bus.o_sa_start     = w_sa_start;
  assign bus.o_sa_sync_rstn = w_sa_sync_rstn;
  assign bus.o_tile_vld     = w_tile_vld;
  assign bus.o_busy         = w_busy;
  assign bus.o_done         = w_done;
  assign bus.o_err          = w_err;
  assign bus.o_row_idx      = r_row;
  assign bus.o_col_idx      = r_col;
endmodule

// File: tb/tb_sa_tile_scheduler.sv
// Directed-plus-random bench for sa_tile_scheduler on a 2x2 tile grid; the array wrapper and tile
// sink are modelled here. Define SA_SCHED_TIMEOUT_EN for both files to exercise the watchdog.
module tb_sa_tile_scheduler;
  localparam int TR = 2;
  localparam int TC = 2;
  localparam int TO = 50;

  // Output vectors {sa_start, sync_rstn, tile_vld, busy, done} expected in each phase of a job.
  localparam logic [4:0] V_IDLE = 5'b00000;
  localparam logic [4:0] V_CLR  = 5'b00010;
  localparam logic [4:0] V_LOAD = 5'b11010;
  localparam logic [4:0] V_RUN  = 5'b01010;
  localparam logic [4:0] V_ACK  = 5'b01110;
  localparam logic [4:0] V_DONE = 5'b01001;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sa_tile_scheduler_if #(.TILE_R(TR), .TILE_C(TC)) bus ();

  sa_tile_scheduler #(.TILE_R(TR), .TILE_C(TC), .TIMEOUT_CYC(TO)) dut (
    .i_clk       (clk),
    .i_asyn_rstn (rst_n),
    .bus         (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  int done_cnt = 0;

  always @(negedge clk) if (bus.o_done === 1'b1) done_cnt++;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input logic [4:0] exp);
    chk(tag, 32'({bus.o_sa_start, bus.o_sa_sync_rstn, bus.o_tile_vld, bus.o_busy, bus.o_done}),
        32'(exp));
  endtask

  task automatic chk_idx(input string tag, input int r, input int c);
    chk(tag, (32'(bus.o_row_idx) << 8) | 32'(bus.o_col_idx), 32'((r << 8) | c));
  endtask

  // One job from IDLE. Tile order comes from walking the grid row by row, columns inner.
  // *_tile arguments select the tile (position in that order) where a disturbance is applied; -1 = none.
  task automatic run_job(input int fixed_lat, input int stall_tile, input int stall_len,
                         input int abort_tile, input int rst_tile, input bit poke_start,
                         input bit start_with_abort);
    int order_r[$];
    int order_c[$];
    int done0;
    int lat;
    int stall;
    for (int r = 0; r < TR; r++)
      for (int c = 0; c < TC; c++) begin
        order_r.push_back(r);
        order_c.push_back(c);
      end
    done0 = done_cnt;
    bus.i_start = 1'b1;
    bus.i_abort = start_with_abort;
    step();
    bus.i_start = 1'b0;
    bus.i_abort = 1'b0;
    chk("err_cleared_on_start", 32'(bus.o_err), 32'd0);
    for (int t = 0; t < order_r.size(); t++) begin
      lat = (fixed_lat > 0) ? fixed_lat : int'($urandom_range(4, 20));
      chk_outs("clr_outs", V_CLR);
      chk_idx("clr_idx", order_r[t], order_c[t]);
      step();
      chk_outs("load_outs", V_LOAD);
      for (int i = 1; i <= lat; i++) begin
        step();
        chk_outs("run_outs", V_RUN);
        if (poke_start && i == 2) bus.i_start = 1'b1;
        if (poke_start && i == 3) bus.i_start = 1'b0;
        if (t == abort_tile && i == 3) begin
          bus.i_abort = 1'b1;
          step();
          bus.i_abort = 1'b0;
          chk_outs("abort_idle_outs", V_IDLE);
          repeat (3) step();
          chk_outs("abort_stays_idle", V_IDLE);
          chk("abort_no_done", 32'(done_cnt), 32'(done0));
          return;
        end
        if (i == lat) bus.i_sa_out_vld = 1'b1;
      end
      step();
      bus.i_sa_out_vld = 1'b0;
      chk_outs("ack_outs", V_ACK);
      chk_idx("ack_idx", order_r[t], order_c[t]);
      if (t == rst_tile) begin
        #2 rst_n = 1'b0;
        #1;
        chk_outs("rst_mid_ack_outs", V_IDLE);
        chk_idx("rst_mid_ack_idx", 0, 0);
        chk("rst_mid_ack_err", 32'(bus.o_err), 32'd0);
        step();
        rst_n = 1'b1;
        step();
        chk_outs("after_rst_idle", V_IDLE);
        chk("rst_no_done", 32'(done_cnt), 32'(done0));
        return;
      end
      stall = (t == stall_tile) ? stall_len : int'($urandom_range(0, 2));
      if (stall > 0) begin
        bus.i_tile_rdy = 1'b0;
        for (int k = 0; k < stall; k++) begin
          step();
          chk_outs("stall_outs", V_ACK);
          chk_idx("stall_idx", order_r[t], order_c[t]);
        end
        bus.i_tile_rdy = 1'b1;
      end
      step();
    end
    chk_outs("done_outs", V_DONE);
    step();
    chk_outs("idle_after_done", V_IDLE);
    chk_idx("idle_idx_retained", TR - 1, TC - 1);
    chk("job_err", 32'(bus.o_err), 32'd0);
    chk("done_once", 32'(done_cnt), 32'(done0 + 1));
  endtask

  initial begin
    bus.i_start      = 1'b0;
    bus.i_abort      = 1'b0;
    bus.i_sa_out_vld = 1'b0;
    bus.i_tile_rdy   = 1'b1;
    repeat (2) step();
    chk_outs("reset_outs", V_IDLE);
    chk_idx("reset_idx", 0, 0);
    chk("reset_err", 32'(bus.o_err), 32'd0);
    rst_n = 1'b1;
    step();
    chk_outs("idle_outs", V_IDLE);

    // Baseline: array answers 32 cycles after its start pulse, sink always ready.
    run_job(32, -1, 0, -1, -1, 1'b0, 1'b0);
    // Sink stalls for 10 cycles on tile (0,1).
    run_job(0, 1, 10, -1, -1, 1'b0, 1'b0);
    // Abort while tile (1,0) is running, then a fresh job restarts from (0,0).
    run_job(0, -1, 0, 2, -1, 1'b0, 1'b0);
    run_job(0, -1, 0, -1, -1, 1'b0, 1'b0);
    // Start pulsed during RUN must be ignored.
    run_job(0, -1, 0, -1, -1, 1'b1, 1'b0);
    // Start together with abort in IDLE is still honoured.
    run_job(0, -1, 0, -1, -1, 1'b0, 1'b1);
    // Reset asserted in the middle of ACK for tile (1,1).
    run_job(0, -1, 0, -1, 3, 1'b0, 1'b0);
    // Random jobs with random latencies and stalls.
    for (int j = 0; j < 3; j++) run_job(0, int'($urandom_range(0, 3)), int'($urandom_range(1, 5)),
                                        -1, -1, 1'b0, 1'b0);

`ifdef SA_SCHED_TIMEOUT_EN
    // Watchdog: array never answers; error appears exactly TO cycles after RUN entry.
    bus.i_start = 1'b1;
    step();
    bus.i_start = 1'b0;
    chk_outs("wd_clr", V_CLR);
    step();
    chk_outs("wd_load", V_LOAD);
    for (int i = 1; i <= TO + 1; i++) begin
      step();
      if (i == TO) begin
        chk_outs("wd_still_run", V_RUN);
        chk("wd_err_not_yet", 32'(bus.o_err), 32'd0);
      end
      if (i == TO + 1) begin
        chk_outs("wd_idle", V_IDLE);
        chk("wd_err_set", 32'(bus.o_err), 32'd1);
      end
    end
    repeat (3) step();
    chk("wd_err_sticky", 32'(bus.o_err), 32'd1);
    run_job(0, -1, 0, -1, -1, 1'b0, 1'b0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
